// File: rtl/disk_dma.sv
// disk_dma: sector DMA engine between main memory and the disk controller's sector buffer.
//
// The CPU programs MEMBASE, LSA, COUNT and CTRL. The engine then moves whole sectors:
//   dir = 1 (memory -> disk): fill the buffer from memory, then command a disk write.
//   dir = 0 (disk -> memory): command a disk read, then drain the buffer to memory.
// Each disk command is a Start write to the controller's command register. The engine then
// waits for the controller's Ready bit to fall and rise again, with a per-command timeout.
//
// Ports
//   clk_CPU, rst         system clock, synchronous active-high reset
//   reg_sel/we/wdata     CPU register write port (0 MEMBASE, 1 LSA, 2 COUNT, 3 CTRL)
//   reg_rdata            combinational read of the selected register
//   irq                  done & irq_en
//   uc_we/uc_wdata       command register write to the disk controller
//   uc_status            controller status, bit 6 = Ready (foreign clock domain)
//   buf_*                sector buffer port (read data has one cycle of latency)
//   mm_*                 main-memory request/acknowledge port
module disk_dma #(
  parameter int unsigned SECTOR_WORDS = 128,
  parameter logic [31:0] TIMEOUT      = 32'd50_000_000
) (
  input  logic        clk_CPU,
  input  logic        rst,
  input  logic [1:0]  reg_sel,
  input  logic        reg_we,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq,
  output logic [3:0]  uc_we,
  output logic [31:0] uc_wdata,
  input  logic [31:0] uc_status,
  output logic [6:0]  buf_addr,
  output logic        buf_we,
  output logic [31:0] buf_wdata,
  input  logic [31:0] buf_rdata,
  output logic        mm_req,
  output logic        mm_we,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ack
);

  localparam logic [6:0]  LastIdx     = 7'(SECTOR_WORDS - 1);
  localparam logic [31:0] SectorBytes = 32'(SECTOR_WORDS * 4);

  typedef enum logic [3:0] {
    StIdle,
    StFill,
    StIssue,
    StWaitClr,
    StWaitRdy,
    StDrainRd,
    StDrainWr,
    StNext,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] membase_q, membase_d;
  logic [15:0] lsa_q, lsa_d;
  logic [7:0]  count_q, count_d;
  logic        dir_q, dir_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [1:0]  rdy_sync_q;
  logic        wr_first_q, wr_first_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        busy;
  logic        rdy;
  logic        wr_membase, wr_lsa, wr_count, wr_ctrl, go;
  logic [31:0] word_addr;
  logic [31:0] drain_word;

  // Only Ready is used from the status word.
  logic unused_status;
  assign unused_status = ^{uc_status[31:7], uc_status[5:0]};

  assign busy = (state_q != StIdle);
  assign rdy  = rdy_sync_q[1];
  assign irq  = done_q & irq_en_q;

  assign wr_membase = reg_we && (reg_sel == 2'd0);
  assign wr_lsa     = reg_we && (reg_sel == 2'd1);
  assign wr_count   = reg_we && (reg_sel == 2'd2);
  assign wr_ctrl    = reg_we && (reg_sel == 2'd3);
  assign go         = wr_ctrl && reg_wdata[0];

  assign word_addr = membase_q + {23'b0, idx_q, 2'b00};

  // The buffer only holds the drained word for the first DRAIN_WR cycle (the address is
  // released afterwards), so take it live then and from the capture register on stalls.
  assign drain_word = wr_first_q ? buf_rdata : wr_data_q;

  always_comb begin
    case (reg_sel)
      2'd0:    reg_rdata = membase_q;
      2'd1:    reg_rdata = {16'b0, lsa_q};
      2'd2:    reg_rdata = {24'b0, count_q};
      default: reg_rdata = {16'b0, count_q, 3'b0, irq_en_q, dir_q, err_q, done_q, busy};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    membase_d  = membase_q;
    lsa_d      = lsa_q;
    count_d    = count_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    err_d      = err_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    wr_first_d = 1'b0;
    wr_data_d  = wr_data_q;

    uc_we     = 4'b0000;
    uc_wdata  = 32'b0;
    buf_addr  = 7'b0;
    buf_we    = 1'b0;
    buf_wdata = 32'b0;
    mm_req    = 1'b0;
    mm_we     = 1'b0;
    mm_addr   = 32'b0;
    mm_wdata  = 32'b0;

    // CPU register writes; the FSM below runs afterwards so its updates take priority.
    if (wr_membase && !busy) membase_d = {reg_wdata[31:2], 2'b00};
    if (wr_lsa && !busy)     lsa_d     = reg_wdata[15:0];
    if (wr_count && !busy)   count_d   = reg_wdata[7:0];
    if (wr_ctrl) begin
      irq_en_d = reg_wdata[2];
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (!busy) dir_d = reg_wdata[1];
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          idx_d = 7'd0;
          if (count_q == 8'd0) begin
            state_d = StFinish;
          end else if (reg_wdata[1]) begin
            state_d = StFill;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StFill: begin
        mm_req  = 1'b1;
        mm_addr = word_addr;
        if (mm_ack) begin
          buf_we    = 1'b1;
          buf_addr  = idx_q;
          buf_wdata = mm_rdata;
          if (idx_q == LastIdx) begin
            idx_d   = 7'd0;
            state_d = StIssue;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end

      StIssue: begin
        uc_we    = 4'b1101;
        uc_wdata = {lsa_q, 10'b0, 1'b1, dir_q, 4'b0};
        tmo_d    = 32'd0;
        state_d  = StWaitClr;
      end

      // Ready may still be high from the previous command; wait for it to drop first.
      StWaitClr: begin
        if (tmo_q == TIMEOUT) begin
          uc_we   = 4'b0001;
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (!rdy) state_d = StWaitRdy;
        end
      end

      StWaitRdy: begin
        if (tmo_q == TIMEOUT) begin
          uc_we   = 4'b0001;
          err_d   = 1'b1;
          state_d = StFinish;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (rdy) state_d = dir_q ? StNext : StDrainRd;
        end
      end

      StDrainRd: begin
        buf_addr   = idx_q;
        wr_first_d = 1'b1;
        state_d    = StDrainWr;
      end

      StDrainWr: begin
        mm_req    = 1'b1;
        mm_we     = 1'b1;
        mm_addr   = word_addr;
        mm_wdata  = drain_word;
        wr_data_d = drain_word;
        if (mm_ack) begin
          if (idx_q == LastIdx) begin
            idx_d   = 7'd0;
            state_d = StNext;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = StDrainRd;
          end
        end
      end

      StNext: begin
        lsa_d     = lsa_q + 16'd1;
        membase_d = membase_q + SectorBytes;
        count_d   = count_q - 8'd1;
        idx_d     = 7'd0;
        if (count_q == 8'd1) begin
          state_d = StFinish;
        end else begin
          state_d = dir_q ? StFill : StIssue;
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_CPU) begin
    if (rst) begin
      state_q    <= StIdle;
      membase_q  <= 32'b0;
      lsa_q      <= 16'b0;
      count_q    <= 8'b0;
      dir_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= 7'b0;
      tmo_q      <= 32'b0;
      rdy_sync_q <= 2'b0;
      wr_first_q <= 1'b0;
      wr_data_q  <= 32'b0;
    end else begin
      state_q    <= state_d;
      membase_q  <= membase_d;
      lsa_q      <= lsa_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      rdy_sync_q <= {rdy_sync_q[0], uc_status[6]};
      wr_first_q <= wr_first_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_disk_dma.sv
// tb_disk_dma: randomized bench for disk_dma with a memory, sector-buffer and disk
// controller model; results are checked against the expected effect of each operation.
module tb_disk_dma;

  localparam logic [31:0] Tmo = 32'd1000;

  logic        clk_CPU = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  reg_sel = 2'd0;
  logic        reg_we = 1'b0;
  logic [31:0] reg_wdata = 32'd0;
  logic [31:0] reg_rdata;
  logic        irq;
  logic [3:0]  uc_we;
  logic [31:0] uc_wdata;
  logic [31:0] uc_status = 32'h0000_0040;
  logic [6:0]  buf_addr;
  logic        buf_we;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata = 32'd0;
  logic        mm_req;
  logic        mm_we;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata = 32'd0;
  logic        mm_ack = 1'b0;

  disk_dma #(.SECTOR_WORDS(128), .TIMEOUT(Tmo)) dut (
    .clk_CPU   (clk_CPU),
    .rst       (rst),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .uc_we     (uc_we),
    .uc_wdata  (uc_wdata),
    .uc_status (uc_status),
    .buf_addr  (buf_addr),
    .buf_we    (buf_we),
    .buf_wdata (buf_wdata),
    .buf_rdata (buf_rdata),
    .mm_req    (mm_req),
    .mm_we     (mm_we),
    .mm_addr   (mm_addr),
    .mm_wdata  (mm_wdata),
    .mm_rdata  (mm_rdata),
    .mm_ack    (mm_ack)
  );

  always #5 clk_CPU = ~clk_CPU;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model state
  logic [31:0] mem  [0:16383];
  logic [31:0] bufm [0:127];
  logic [31:0] cap  [0:7][0:127];
  logic [15:0] cap_lsa [0:7];
  int          cap_n = 0;
  logic [31:0] cmd_q[$];
  int  mm_wait = 0, max_wait = 0;
  bit  rdy = 1'b1, dead = 1'b0;
  int  clr_cnt = 0, rdy_cnt = 0;
  logic [15:0] cur_lsa = 16'd0;
  bit  cur_rw = 1'b0;
  int  n_abort = 0, abort_bad = 0, uc_bad = 0, hold_bad = 0, oob_bad = 0, dflt_bad = 0;
  int  n_mm_rd = 0, n_mm_wr = 0, n_req_cycles = 0;

  function automatic logic [31:0] sector_word(input logic [15:0] l, input int k);
    sector_word = {l, 16'(k * 3)};
  endfunction

  // Snapshot DUT outputs mid-cycle, apply their effect just after the next rising edge.
  initial begin : model
    logic s_req, s_ack, s_we, s_bwe, p_req, p_ack;
    logic [31:0] s_addr, s_wdata, s_bwdata, s_uwdata, p_addr;
    logic [6:0] s_baddr;
    logic [3:0] s_uwe;
    p_req = 1'b0;
    p_ack = 1'b0;
    p_addr = 32'd0;
    forever begin
      @(negedge clk_CPU);
      s_req = mm_req; s_ack = mm_ack; s_we = mm_we; s_addr = mm_addr; s_wdata = mm_wdata;
      s_bwe = buf_we; s_baddr = buf_addr; s_bwdata = buf_wdata;
      s_uwe = uc_we; s_uwdata = uc_wdata;
      @(posedge clk_CPU);
      #1;
      if (p_req && !p_ack && (!s_req || s_addr != p_addr)) hold_bad++;
      if (!s_req && (s_we || s_addr != 32'd0 || s_wdata != 32'd0)) dflt_bad++;
      if (!s_bwe && s_bwdata != 32'd0) dflt_bad++;
      if (s_uwe == 4'b0000 && s_uwdata != 32'd0) dflt_bad++;
      if (s_req) begin
        n_req_cycles++;
        if (s_addr[1:0] != 2'b00 || s_addr[31:16] != 16'd0) oob_bad++;
        if (s_ack) begin
          if (s_we) begin
            mem[s_addr[15:2]] = s_wdata;
            n_mm_wr++;
          end else begin
            n_mm_rd++;
          end
          mm_wait = $urandom_range(max_wait, 0);
        end else if (mm_wait > 0) begin
          mm_wait--;
        end
      end
      buf_rdata = bufm[s_baddr];
      if (s_bwe) bufm[s_baddr] = s_bwdata;
      if (s_uwe == 4'b1101) begin
        cmd_q.push_back(s_uwdata);
        cur_lsa = s_uwdata[31:16];
        cur_rw  = s_uwdata[4];
        clr_cnt = $urandom_range(6, 1);
        rdy_cnt = $urandom_range(100, 20);
      end else if (s_uwe == 4'b0001) begin
        n_abort++;
        if (s_uwdata != 32'd0) abort_bad++;
        clr_cnt = 0;
        rdy_cnt = 0;
        rdy = 1'b0;
      end else if (s_uwe != 4'b0000) begin
        uc_bad++;
      end else if (clr_cnt > 0) begin
        clr_cnt--;
        if (clr_cnt == 0) rdy = 1'b0;
      end else if (rdy_cnt > 0 && !dead) begin
        rdy_cnt--;
        if (rdy_cnt == 0) begin
          if (cur_rw) begin
            for (int k = 0; k < 128; k++) cap[cap_n % 8][k] = bufm[k];
            cap_lsa[cap_n % 8] = cur_lsa;
            cap_n++;
          end else begin
            for (int k = 0; k < 128; k++) bufm[k] = sector_word(cur_lsa, k);
          end
          rdy = 1'b1;
        end
      end
      uc_status = {25'd0, rdy, 6'd0};
      mm_ack    = mm_req && (mm_wait == 0);
      mm_rdata  = mm_ack ? mem[mm_addr[15:2]] : $urandom();
      p_req  = s_req;
      p_ack  = s_ack;
      p_addr = s_addr;
    end
  end

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk_CPU);
    reg_sel   = sel;
    reg_wdata = d;
    reg_we    = 1'b1;
    @(negedge clk_CPU);
    reg_we    = 1'b0;
    reg_wdata = 32'd0;
  endtask

  task automatic rd_reg(input logic [1:0] sel, output logic [31:0] d);
    @(negedge clk_CPU);
    reg_sel = sel;
    #1;
    d = reg_rdata;
  endtask

  // Runs one complete transfer and checks registers, disk commands and moved data.
  task automatic run_op(input logic [31:0] base, input logic [15:0] lsa, input int cnt,
                        input bit dir, input bit ien, input string tag);
    int cmd0, cap0, rd0, wr0, cyc, bad, a;
    logic [31:0] v;
    logic [15:0] l;
    bit fin;
    for (int s = 0; s < cnt; s++) begin
      for (int k = 0; k < 128; k++) begin
        a = int'(base[15:2]) + s * 128 + k;
        mem[a] = dir ? $urandom() : 32'hFFFF_FFFF;
      end
    end
    cmd0 = cmd_q.size();
    cap0 = cap_n;
    rd0  = n_mm_rd;
    wr0  = n_mm_wr;
    wr_reg(2'd0, base);
    wr_reg(2'd1, {16'd0, lsa});
    wr_reg(2'd2, 32'(cnt));
    wr_reg(2'd3, {29'd0, ien, dir, 1'b1});
    if (dir) begin
      check({tag, "_fill_first_req"}, 32'(mm_req), 32'd1);
      check({tag, "_fill_first_addr"}, mm_addr, base);
    end else begin
      check({tag, "_issue_first_cycle"}, 32'(uc_we), 32'hD);
    end
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < cnt * 2500 + 200) begin
      rd_reg(2'd3, v);
      fin = v[1];
      cyc++;
    end
    check({tag, "_done_in_time"}, 32'(fin), 32'd1);
    rd_reg(2'd3, v);
    check({tag, "_ctrl"}, v, {27'd0, ien, dir, 3'b010});
    check({tag, "_irq"}, 32'(irq), 32'(ien));
    rd_reg(2'd1, v);
    check({tag, "_lsa_final"}, v, {16'd0, lsa + 16'(cnt)});
    rd_reg(2'd0, v);
    check({tag, "_membase_final"}, v, base + 32'(cnt * 512));
    check({tag, "_cmd_count"}, 32'(cmd_q.size() - cmd0), 32'(cnt));
    for (int s = 0; s < cnt; s++) begin
      l = lsa + 16'(s);
      if (cmd0 + s < cmd_q.size())
        check({tag, "_cmd_word"}, cmd_q[cmd0 + s], {l, 10'd0, 1'b1, dir, 4'd0});
    end
    bad = 0;
    if (!dir) begin
      for (int s = 0; s < cnt; s++) begin
        for (int k = 0; k < 128; k++) begin
          a = int'(base[15:2]) + s * 128 + k;
          if (mem[a] !== sector_word(lsa + 16'(s), k)) bad++;
        end
      end
      check({tag, "_mem_words_wrong"}, 32'(bad), 32'd0);
      check({tag, "_mem_writes"}, 32'(n_mm_wr - wr0), 32'(cnt * 128));
      check({tag, "_mem_reads"}, 32'(n_mm_rd - rd0), 32'd0);
    end else begin
      for (int s = 0; s < cnt; s++) begin
        if (cap_lsa[(cap0 + s) % 8] !== lsa + 16'(s)) bad++;
        for (int k = 0; k < 128; k++) begin
          a = int'(base[15:2]) + s * 128 + k;
          if (cap[(cap0 + s) % 8][k] !== mem[a]) bad++;
        end
      end
      check({tag, "_disk_words_wrong"}, 32'(bad), 32'd0);
      check({tag, "_mem_reads"}, 32'(n_mm_rd - rd0), 32'(cnt * 128));
      check({tag, "_mem_writes"}, 32'(n_mm_wr - wr0), 32'd0);
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] v;
    int cyc, cmd0, req0, ab0;
    bit fin;
    logic [31:0] base;
    logic [15:0] lsa;

    repeat (3) @(negedge clk_CPU);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      check("reset_reg", v, 32'd0);
    end
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_mm_req", 32'(mm_req), 32'd0);
    check("reset_uc_we", 32'(uc_we), 32'd0);

    // Single-sector read, zero-wait memory
    max_wait = 0;
    run_op(32'h1000, 16'h0005, 1, 1'b0, 1'b1, "rd1");
    check("rd1_cmd_literal", cmd_q[cmd_q.size() - 1], 32'h0005_0020);

    // Two-sector write across the LSA wrap
    run_op(32'h2000, 16'hFFFF, 2, 1'b1, 1'b0, "wr2");
    check("wr2_cmd0_literal", cmd_q[cmd_q.size() - 2], 32'hFFFF_0030);
    check("wr2_cmd1_literal", cmd_q[cmd_q.size() - 1], 32'h0000_0030);

    // COUNT = 0
    cmd0 = cmd_q.size();
    req0 = n_req_cycles;
    wr_reg(2'd2, 32'd0);
    wr_reg(2'd3, 32'h5);
    reg_sel = 2'd3;
    #1;
    check("cnt0_busy_first", reg_rdata & 32'h3, 32'h1);
    rd_reg(2'd3, v);
    check("cnt0_ctrl", v, 32'h12);
    check("cnt0_irq", 32'(irq), 32'd1);
    check("cnt0_no_cmd", 32'(cmd_q.size() - cmd0), 32'd0);
    check("cnt0_no_req", 32'(n_req_cycles - req0), 32'd0);
    wr_reg(2'd3, 32'h4);
    rd_reg(2'd3, v);
    check("ctrl_write_clears_done", v, 32'h10);
    check("ctrl_write_clears_irq", 32'(irq), 32'd0);

    // Timeout: Ready never rises
    dead = 1'b1;
    ab0 = n_abort;
    wr_reg(2'd0, 32'h3000);
    wr_reg(2'd1, 32'h0100);
    wr_reg(2'd2, 32'd1);
    wr_reg(2'd3, 32'h5);
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 1500) begin
      rd_reg(2'd3, v);
      fin = v[1];
      if (!fin) cyc++;
    end
    check("tmo_ctrl", v, 32'h116);
    check("tmo_latency_ok", 32'(cyc >= 995 && cyc <= 1010), 32'd1);
    check("tmo_abort_count", 32'(n_abort - ab0), 32'd1);
    check("tmo_abort_wdata", 32'(abort_bad), 32'd0);
    dead = 1'b0;

    // Reset while waiting for Ready
    max_wait = 2;
    cmd0 = cmd_q.size();
    wr_reg(2'd0, 32'h4000);
    wr_reg(2'd1, 32'h0ABC);
    wr_reg(2'd2, 32'd2);
    wr_reg(2'd3, 32'h1);
    cyc = 0;
    while (cmd_q.size() == cmd0 && cyc < 50) begin
      @(negedge clk_CPU);
      cyc++;
    end
    check("rst_cmd_issued", 32'(cmd_q.size() - cmd0), 32'd1);
    repeat (12) @(negedge clk_CPU);
    rst = 1'b1;
    @(negedge clk_CPU);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rd_reg(2'(r), v);
      check("rst_mid_reg", v, 32'd0);
    end
    cyc = 0;
    while (uc_status[6] == 1'b0 && cyc < 300) begin
      @(negedge clk_CPU);
      cyc++;
    end
    check("rst_stale_ready_high", 32'(uc_status[6]), 32'd1);
    run_op(32'h5000, 16'h0ABD, 1, 1'b0, 1'b1, "post_rst");

    // Random operations with memory stalls
    for (int t = 0; t < 5; t++) begin
      max_wait = $urandom_range(5, 0);
      base = 32'($urandom_range(32'h7000, 0)) & 32'hFFFF_FFFC;
      lsa = ($urandom_range(2, 0) == 0) ? 16'hFFFE : 16'($urandom());
      run_op(base, lsa, $urandom_range(3, 1), 1'($urandom()), 1'($urandom()), "rand");
    end

    check("req_held_until_ack", 32'(hold_bad), 32'd0);
    check("outputs_default_zero", 32'(dflt_bad), 32'd0);
    check("uc_we_values_legal", 32'(uc_bad), 32'd0);
    check("mm_addr_aligned_in_range", 32'(oob_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
